// File: rtl/e_responder.sv
// 6800-style E-clock peripheral responder: 15 R/W scratch bytes plus a read-only access counter at index 0xF.
// Latency: VPA_n falls 1 CLK after a valid select; data moves in E phases 6..9 after VMA_n; VPA_n rises 1 CLK after AS_n.
// Backpressure: the initiator paces the cycle with VMA_n and AS_n; optional macro E_GEN_EN generates E locally instead of tracking a_E.
module e_responder #(
    parameter int E_PERIOD = 10
) (
    input  logic       CLK,
    input  logic       HARDRESET,
    input  logic       a_E,
    output logic       E_OUT,
    input  logic       AS_n,
    input  logic       RW,
    input  logic       LDS_n,
    input  logic       SEL,
    input  logic [3:0] ADDR,
    input  logic       VMA_n,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    output logic       VPA_n,
    output logic       LOCKED
);

    localparam int PW = $clog2(E_PERIOD);
    // Last phase of the period, and the phase just before E rises (entry into ACCESS).
    localparam logic [PW-1:0] PH_LAST = PW'(E_PERIOD - 1);
    localparam logic [PW-1:0] PH_PRE  = PW'(E_PERIOD - 5);

    typedef enum logic [1:0] {IDLE, WAIT_VMA, ACCESS, DONE} state_t;

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;
    state_t        state;
    logic [3:0]    idx;
    logic          rw_q;
    logic [7:0]    regs [0:14];
    logic [7:0]    acc_cnt;
    logic [7:0]    rd_dat;

    // Next E phase, wrapping at the end of the period.
    always_comb begin
        phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
    end

`ifdef E_GEN_EN
    localparam logic [PW-1:0] PH_HI = PW'(E_PERIOD - 4);

    // Free-running local E: E_OUT is taken from the next phase so it is high exactly during phases 6..9.
    always_ff @(posedge CLK or posedge HARDRESET) begin
        if (HARDRESET) begin
            phase <= '0;
            E_OUT <= 1'b0;
        end else begin
            phase <= phase_nxt;
            E_OUT <= (phase_nxt >= PH_HI);
        end
    end

    assign LOCKED = 1'b1;
`else
    logic e_s1, e_s2, e_s3;

    // Synchronise a_E, lock on the first falling edge, then free-run without re-checking E.
    // The load value 2 accounts for the two synchroniser stages plus the edge-history stage.
    always_ff @(posedge CLK or posedge HARDRESET) begin
        if (HARDRESET) begin
            e_s1   <= 1'b0;
            e_s2   <= 1'b0;
            e_s3   <= 1'b0;
            phase  <= '0;
            LOCKED <= 1'b0;
        end else begin
            e_s1 <= a_E;
            e_s2 <= e_s1;
            e_s3 <= e_s2;
            if (!LOCKED) begin
                if (e_s3 && !e_s2) begin
                    phase  <= PW'(2);
                    LOCKED <= 1'b1;
                end
            end else begin
                phase <= phase_nxt;
            end
        end
    end

    assign E_OUT = 1'b0;
`endif

    // Register window read mux; index 0xF is the access counter.
    always_comb begin
        rd_dat = 8'h00;
        if (idx == 4'hF) rd_dat = acc_cnt;
        else             rd_dat = regs[idx];
    end

    // VPA/VMA/E handshake FSM with registered bus outputs and register file.
    always_ff @(posedge CLK or posedge HARDRESET) begin
        if (HARDRESET) begin
            state   <= IDLE;
            VPA_n   <= 1'b1;
            D_OE    <= 1'b0;
            D_OUT   <= 8'h00;
            idx     <= 4'h0;
            rw_q    <= 1'b0;
            acc_cnt <= 8'h00;
            for (int i = 0; i < 15; i++) regs[i] <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (!AS_n && SEL && !LDS_n && LOCKED) begin
                        idx   <= ADDR;
                        rw_q  <= RW;
                        VPA_n <= 1'b0;
                        state <= WAIT_VMA;
                    end
                end
                WAIT_VMA: begin
                    if (AS_n) begin
                        VPA_n <= 1'b1;
                        state <= IDLE;
                    end else if (!VMA_n && phase == PH_PRE) begin
                        state <= ACCESS;
                        D_OE  <= rw_q;
                        if (rw_q) D_OUT <= rd_dat;
                    end
                end
                ACCESS: begin
                    if (AS_n) begin
                        VPA_n <= 1'b1;
                        D_OE  <= 1'b0;
                        state <= IDLE;
                    end else if (phase == PH_LAST) begin
                        if (!rw_q && idx != 4'hF) regs[idx] <= D_IN;
                        acc_cnt <= acc_cnt + 1'b1;
                        D_OE    <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (AS_n) begin
                        VPA_n <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_responder.sv
// Bench for e_responder in the external-E build: drives a_E from its own phase count,
// runs directed and random bus cycles against a transaction-level register model.
// Outputs are sampled 3 time units after each rising CLK edge.
module tb_e_responder;

    logic       CLK = 1'b0;
    logic       HARDRESET;
    logic       a_E = 1'b0;
    logic       E_OUT;
    logic       AS_n, RW, LDS_n, SEL, VMA_n;
    logic [3:0] ADDR;
    logic [7:0] D_IN;
    logic [7:0] D_OUT;
    logic       D_OE, VPA_n, LOCKED;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_reg [0:15];
    logic [7:0] m_cnt;
    int         bp = 0;
    bit         e_run = 1'b0;
    int         guard;
    logic       e_prev;

    e_responder #(.E_PERIOD(10)) dut (
        .CLK(CLK), .HARDRESET(HARDRESET), .a_E(a_E), .E_OUT(E_OUT),
        .AS_n(AS_n), .RW(RW), .LDS_n(LDS_n), .SEL(SEL), .ADDR(ADDR),
        .VMA_n(VMA_n), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
        .VPA_n(VPA_n), .LOCKED(LOCKED)
    );

    always #5 CLK = ~CLK;

    // External E source: bp is the E phase of the cycle following each edge; E low for 6, high for 4.
    always @(posedge CLK) begin
        #2;
        bp  = (bp == 9) ? 0 : bp + 1;
        a_E = e_run && (bp >= 5) && (bp <= 8);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #3;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        AS_n = 1'b1; SEL = 1'b0; LDS_n = 1'b1; RW = 1'b1; VMA_n = 1'b1;
        ADDR = 4'h0; D_IN = 8'h00;
    endtask

    // One complete bus cycle; expectations come from the register model.
    task automatic do_access(input logic rw, input logic [3:0] a, input logic [7:0] wd, input int vma_dly);
        logic [7:0] exp_rd;
        int         g;
        exp_rd = (a == 4'hF) ? m_cnt : m_reg[a];
        AS_n = 1'b0; SEL = 1'b1; LDS_n = 1'b0; RW = rw; ADDR = a; D_IN = wd; VMA_n = 1'b1;
        tick();
        chk("vpa_fall", VPA_n, 1'b0);
        repeat (vma_dly) begin
            tick();
            chk("wait_oe", D_OE, 1'b0);
        end
        VMA_n = 1'b0;
        for (g = 0; g < 25; g++) begin
            tick();
            if (bp == 6) break;
            chk("wait_vpa", VPA_n, 1'b0);
            chk("wait_oe2", D_OE, 1'b0);
        end
        chk("vma_timeout", (g < 25), 1'b1);
        for (int p = 6; p <= 9; p++) begin
            chk("acc_oe", D_OE, rw);
            if (rw) chk("acc_dout", D_OUT, exp_rd);
            chk("acc_vpa", VPA_n, 1'b0);
            if (p != 9) tick();
        end
        tick();
        chk("done_oe", D_OE, 1'b0);
        chk("done_vpa", VPA_n, 1'b0);
        if (!rw && a != 4'hF) m_reg[a] = wd;
        m_cnt = m_cnt + 8'd1;
        bus_idle();
        tick();
        chk("vpa_rise", VPA_n, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
        m_cnt = 8'h00;
        bus_idle();
        HARDRESET = 1'b1;
        tick();
        chk("rst_vpa", VPA_n, 1'b1);
        chk("rst_oe", D_OE, 1'b0);
        chk("rst_dout", D_OUT, 8'h00);
        chk("rst_eout", E_OUT, 1'b0);
        chk("rst_lock", LOCKED, 1'b0);
        HARDRESET = 1'b0;
        tick();

        // Access attempted before any E fall: no response.
        AS_n = 1'b0; SEL = 1'b1; LDS_n = 1'b0; RW = 1'b1; ADDR = 4'h3;
        repeat (3) begin
            tick();
            chk("prelock_vpa", VPA_n, 1'b1);
        end
        chk("prelock_lock", LOCKED, 1'b0);
        bus_idle();
        tick();

        // Start E and find its first falling edge.
        e_run = 1'b1;
        e_prev = a_E;
        for (guard = 0; guard < 40; guard++) begin
            e_prev = a_E;
            tick();
            if (e_prev && !a_E) break;
        end
        tick();
        chk("lock_t1", LOCKED, 1'b0);
        tick();
        chk("lock_t2", LOCKED, 1'b0);
        tick();
        chk("lock_t3", LOCKED, 1'b1);
        chk("lock_phase", 8'(dut.phase), 8'd2);
        tick();

        // Directed: write A5 to idx 3, read it back, then read the counter.
        do_access(1'b0, 4'h3, 8'hA5, 0);
        do_access(1'b1, 4'h3, 8'h00, 2);
        do_access(1'b1, 4'hF, 8'h00, 5);

        // No response to SEL=0 or upper-lane-only cycles.
        AS_n = 1'b0; SEL = 1'b0; LDS_n = 1'b0;
        tick(); tick();
        chk("nosel_vpa", VPA_n, 1'b1);
        SEL = 1'b1; LDS_n = 1'b1;
        tick(); tick();
        chk("uds_vpa", VPA_n, 1'b1);
        bus_idle();
        tick();

        // Abort during WAIT_VMA after a completed write to idx 5.
        do_access(1'b0, 4'h5, 8'h11, 1);
        AS_n = 1'b0; SEL = 1'b1; LDS_n = 1'b0; RW = 1'b0; ADDR = 4'h5; D_IN = 8'hEE; VMA_n = 1'b1;
        tick();
        chk("abort_vpa0", VPA_n, 1'b0);
        tick(); tick();
        bus_idle();
        tick();
        chk("abort_vpa1", VPA_n, 1'b1);
        chk("abort_oe", D_OE, 1'b0);
        tick();
        do_access(1'b1, 4'h5, 8'h00, 0);
        do_access(1'b1, 4'hF, 8'h00, 0);

        // Random cycles against the model.
        for (int n = 0; n < 40; n++) begin
            do_access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      8'($urandom), $urandom_range(0, 12));
        end

        // Run the counter to 256 completed accesses, then check wrap and the read-only slot.
        while (m_cnt != 8'h00) do_access(1'b1, 4'($urandom_range(0, 14)), 8'h00, 0);
        do_access(1'b1, 4'hF, 8'h00, 0);
        do_access(1'b0, 4'hF, 8'h55, 0);
        do_access(1'b1, 4'hF, 8'h00, 0);

        // HARDRESET during the ACCESS phase of a write to idx 7.
        do_access(1'b0, 4'h7, 8'h77, 1);
        AS_n = 1'b0; SEL = 1'b1; LDS_n = 1'b0; RW = 1'b0; ADDR = 4'h7; D_IN = 8'h99; VMA_n = 1'b0;
        tick();
        chk("hr_vpa0", VPA_n, 1'b0);
        for (guard = 0; guard < 25; guard++) begin
            if (bp == 7) break;
            tick();
        end
        chk("hr_vpa_acc", VPA_n, 1'b0);
        HARDRESET = 1'b1;
        #1;
        chk("hr_vpa", VPA_n, 1'b1);
        chk("hr_oe", D_OE, 1'b0);
        chk("hr_lock", LOCKED, 1'b0);
        #1;
        HARDRESET = 1'b0;
        bus_idle();
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
        m_cnt = 8'h00;
        for (guard = 0; guard < 40; guard++) begin
            tick();
            if (LOCKED) break;
        end
        chk("relock", LOCKED, 1'b1);
        tick();
        do_access(1'b1, 4'h7, 8'h00, 0);
        do_access(1'b1, 4'hF, 8'h00, 3);
        chk("eout_const", E_OUT, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
